mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 34 +++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state encoding and device strobe constants
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    RESP
  } state_e;

  // Device strobes are two bits wide but only ever carry 0 or 1.
  localparam logic [1:0] CS_SEL   = 2'd0;
  localparam logic [1:0] CS_DESEL = 2'd1;
  localparam logic [1:0] WE_WRITE = 2'd0;
  localparam logic [1:0] WE_READ  = 2'd1;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - loadable 4-bit down-counter with a last-cycle flag
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       last
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding host-to-device access sequencer
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_rdata,
  output logic       rsp_write,
  output logic [3:0] mem_a,
  output logic [3:0] mem_d,
  input  logic [3:0] mem_o,
  output logic [1:0] mem_we,
  output logic [1:0] mem_cs
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [1:0] cs_q, cs_d;
  logic [1:0] we_q, we_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [3:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_write_q, rsp_write_d;

  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_last;
  logic [3:0] tmr_count;

  mem_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .last     (tmr_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cs_d        = cs_q;
    we_d        = we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = SETUP;
        end
      end
      SETUP: begin
        tmr_load = 1'b1;
        cs_d     = CS_SEL;
        we_d     = write_q ? WE_WRITE : WE_READ;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (tmr_last) begin
          // Strobe and select drop together so we never moves while selected.
          cs_d        = CS_DESEL;
          we_d        = WE_READ;
          rsp_write_d = write_q;
          rsp_rdata_d = write_q ? 4'h0 : ~mem_o;
          if (write_q) begin
            state_d = HOLD;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 4'h0;
      wdata_q     <= 4'h0;
      write_q     <= 1'b0;
      cs_q        <= CS_DESEL;
      we_q        <= WE_READ;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 4'h0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_write = rsp_write_q;
  assign mem_a     = addr_q;
  assign mem_d     = wdata_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [3:0] req_addr = 4'h0, req_wdata = 4'h0;
  logic       req_ready, rsp_valid, rsp_write;
  logic [3:0] rsp_rdata, mem_a, mem_d, mem_o;
  logic [1:0] mem_we, mem_cs;

  logic       req_valid4 = 1'b0;
  logic [3:0] req_addr4 = 4'h0;
  logic       req_ready4, rsp_valid4, rsp_write4;
  logic [3:0] rsp_rdata4, mem_a4, mem_d4, mem_o4;
  logic [1:0] mem_we4, mem_cs4;

  typedef struct packed {logic w; logic [3:0] d;} exp_t;
  exp_t       exp_q[$];
  logic [3:0] model[16];
  logic [3:0] dev1[16];
  logic [3:0] dev4[16];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .mem_a(mem_a), .mem_d(mem_d), .mem_o(mem_o),
    .mem_we(mem_we), .mem_cs(mem_cs)
  );

  mem_access_ctrl #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_write(1'b0), .req_addr(req_addr4), .req_wdata(4'h0),
    .rsp_valid(rsp_valid4), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata4),
    .rsp_write(rsp_write4), .mem_a(mem_a4), .mem_d(mem_d4), .mem_o(mem_o4),
    .mem_we(mem_we4), .mem_cs(mem_cs4)
  );

  // Device models: store on a selected write strobe, return the complement.
  always @(posedge clk) begin
    if (mem_cs == CS_SEL && mem_we == WE_WRITE) dev1[mem_a] <= mem_d;
  end
  assign mem_o  = ~dev1[mem_a];
  assign mem_o4 = ~dev4[mem_a4];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_write", rsp_write, e.w);
        chk("rsp_rdata", rsp_rdata, e.d);
      end
    end
  end

  logic [1:0] prev_cs = CS_DESEL, prev_we = WE_READ;
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_cs > 2'd1 || mem_we > 2'd1) chk("strobe_legal", 0, 1);
      if (prev_cs == CS_SEL && mem_cs == CS_SEL) chk("we_stable_while_sel", mem_we, prev_we);
    end
    prev_cs = mem_cs;
    prev_we = mem_we;
  end

  task automatic do_req(input logic w, input logic [3:0] a, input logic [3:0] d, input int exp_lat);
    int   n;
    int   cs0;
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    e.w = w;
    e.d = w ? 4'h0 : model[a];
    if (w) model[a] = d;
    exp_q.push_back(e);
    @(posedge clk);
    n = 1; cs0 = 0;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    while (!rsp_valid && n < 50) begin
      if (mem_cs == CS_SEL) begin
        cs0++;
        chk("access_addr", mem_a, a);
        chk("access_we", mem_we, w ? WE_WRITE : WE_READ);
        if (w) chk("access_data", mem_d, d);
      end
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("latency", n, exp_lat);
    chk("cs_window", cs0, 1);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   cs0;
    exp_t e;
    for (int i = 0; i < 16; i++) dev4[i] = 4'(i) ^ 4'hC;

    #12;
    chk("rst_cs", mem_cs, CS_DESEL);
    chk("rst_we", mem_we, WE_READ);
    chk("rst_a", mem_a, 0);
    chk("rst_d", mem_d, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_rsp_write", rsp_write, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);

    do_req(1'b1, 4'h3, 4'hA, 4);
    do_req(1'b0, 4'h3, 4'h0, 3);

    // Stalled response: everything frozen, new requests ignored.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h3;
    e.w = 1'b0; e.d = 4'hA; exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 10; i++) begin
      req_addr = 4'(i);
      req_write = i[0];
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 4'hA);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_cs", mem_cs, CS_DESEL);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);

    for (int a = 0; a < 16; a++) do_req(1'b1, 4'(a), 4'($urandom_range(0, 15)), 4);
    for (int a = 15; a >= 0; a--) do_req(1'b0, 4'(a), 4'h0, 3);

    // Abort a write mid-access; it must neither respond nor reach the device.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h5; req_wdata = ~model[5];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 chk("abort_in_access", mem_cs, CS_SEL);
    rst = 1'b1;
    #1;
    chk("abort_cs_async", mem_cs, CS_DESEL);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_abort", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_req(1'b0, 4'h6, 4'h0, 3);
    do_req(1'b0, 4'h5, 4'h0, 3);

    // Long wait window on the second instance.
    @(negedge clk);
    req_valid4 = 1'b1; req_addr4 = 4'h5;
    @(posedge clk);
    n = 1; cs0 = 0;
    @(negedge clk);
    req_valid4 = 1'b0; req_addr4 = 4'h9;
    while (!rsp_valid4 && n < 50) begin
      if (mem_cs4 == CS_SEL) begin
        cs0++;
        chk("w4_addr", mem_a4, 5);
        chk("w4_we", mem_we4, WE_READ);
      end
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("w4_latency", n, 6);
    chk("w4_cs_window", cs0, 4);
    chk("w4_rdata", rsp_rdata4, 4'h5 ^ 4'hC);
    chk("w4_rsp_write", rsp_write4, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
